// File: rtl/lab4_branch_resolve_queue_pkg.sv
// Shared types and helpers for the branch resolve queue slice.
package lab4_branch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic        pred_taken;
  } resolve_entry_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_UPDATE = 1'b1
  } resolve_state_t;

  localparam int DEPTH_DEF    = 32'sd4;
  localparam int PHT_SIZE_DEF = 32'sd2048;

  // Elaboration-time sanity check for power-of-two sizes.
  function automatic logic is_pow2_ge2(input int n);
    return (n >= 32'sd2) && ((n & (n - 32'sd1)) == 32'sd0);
  endfunction

  // A mispredict is any disagreement between prediction and outcome.
  function automatic logic mispredict_of(input resolve_entry_t e, input logic taken);
    return e.pred_taken ^ taken;
  endfunction

endpackage

// File: rtl/lab4_branch_resolve_queue_if.sv
// Fetch/execute/PHT side bundle of the branch resolve queue.
// master: the pipeline driving predictions, outcomes and PHT saturation flags.
// slave:  the resolve queue itself.
interface lab4_branch_resolve_queue_if;
  logic        pred_val;
  logic        pred_rdy;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        resolve_val;
  logic        resolve_rdy;
  logic        resolve_taken;
  logic        flush;
  logic        upd_val;
  logic [31:0] upd_pc;
  logic        upd_increment;
  logic        upd_decrement;
  logic        entry_upper_reached;
  logic        entry_lower_reached;
  logic        mispredict;

  modport master (
    output pred_val, pred_pc, pred_taken, resolve_val, resolve_taken, flush,
           entry_upper_reached, entry_lower_reached,
    input  pred_rdy, resolve_rdy, upd_val, upd_pc, upd_increment, upd_decrement,
           mispredict
  );

  modport slave (
    input  pred_val, pred_pc, pred_taken, resolve_val, resolve_taken, flush,
           entry_upper_reached, entry_lower_reached,
    output pred_rdy, resolve_rdy, upd_val, upd_pc, upd_increment, upd_decrement,
           mispredict
  );
endinterface

// File: rtl/lab4_branch_resolve_queue_fifo.sv
// In-order FIFO of in-flight branch predictions.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module lab4_branch_resolve_fifo
  import lab4_branch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enq,
  input  resolve_entry_t enq_data,
  input  logic           deq,
  input  logic           flush,
  output logic           full,
  output logic           empty,
  output resolve_entry_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]  wr_ptr_r;
  logic [PW-1:0]  rd_ptr_r;
  resolve_entry_t mem_r [DEPTH];
  logic           do_enq_s;
  logic           do_deq_s;

  assign full     = (wr_ptr_r[PW-1] != rd_ptr_r[PW-1]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty    = (wr_ptr_r == rd_ptr_r);
  assign head     = mem_r[rd_ptr_r[AW-1:0]];
  assign do_enq_s = enq && !full && !flush;
  assign do_deq_s = deq && !empty && !flush;

  // Advance pointers; flush discards everything by collapsing both pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_enq_s) wr_ptr_r <= wr_ptr_r + PW'(1'b1);
      if (do_deq_s) rd_ptr_r <= rd_ptr_r + PW'(1'b1);
    end
  end

  // Slot storage, written at the tail on enqueue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (do_enq_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= enq_data;
    end
  end

endmodule

// File: rtl/lab4_branch_resolve_queue.sv
// In-flight branch tracker and PHT update stage.
// Optional feature macro: BRANCH_STATS_EN adds stat_branches / stat_mispredicts counters.
module lab4_branch_resolve_queue
  import lab4_branch_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int PHT_size = PHT_SIZE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  lab4_branch_resolve_queue_if.slave bus
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  if (!is_pow2_ge2(DEPTH)) begin : g_depth_chk
    $error("DEPTH must be a power of two and at least 2");
  end
  if (!is_pow2_ge2(PHT_size)) begin : g_pht_chk
    $error("PHT_size must be a power of two and at least 2");
  end

  resolve_state_t state_r;
  logic           upd_val_r;
  logic [31:0]    upd_pc_r;
  logic           taken_r;
  logic           mispredict_r;
  logic           full_s;
  logic           empty_s;
  resolve_entry_t head_s;
  resolve_entry_t enq_data_s;
  logic           pred_rdy_s;
  logic           resolve_rdy_s;
  logic           enq_s;
  logic           deq_s;

  // Ready signals are gated by reset so they drop immediately on assertion.
  assign pred_rdy_s    = reset && !full_s && !bus.flush;
  assign resolve_rdy_s = reset && !empty_s && (state_r == ST_IDLE) && !bus.flush;
  assign enq_s         = bus.pred_val && pred_rdy_s;
  assign deq_s         = bus.resolve_val && resolve_rdy_s;
  assign enq_data_s    = '{pc: bus.pred_pc, pred_taken: bus.pred_taken};

  lab4_branch_resolve_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .enq      (enq_s),
    .enq_data (enq_data_s),
    .deq      (deq_s),
    .flush    (bus.flush),
    .full     (full_s),
    .empty    (empty_s),
    .head     (head_s)
  );

  // Resolve FSM: latch the head outcome on fire, present a one-cycle PHT update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      upd_val_r    <= 1'b0;
      upd_pc_r     <= 32'h0000_0000;
      taken_r      <= 1'b0;
      mispredict_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (deq_s) begin
            state_r      <= ST_UPDATE;
            upd_val_r    <= 1'b1;
            upd_pc_r     <= head_s.pc;
            taken_r      <= bus.resolve_taken;
            mispredict_r <= mispredict_of(head_s, bus.resolve_taken);
          end else begin
            state_r      <= ST_IDLE;
            upd_val_r    <= 1'b0;
            upd_pc_r     <= 32'h0000_0000;
            taken_r      <= 1'b0;
            mispredict_r <= 1'b0;
          end
        end
        ST_UPDATE: begin
          state_r      <= ST_IDLE;
          upd_val_r    <= 1'b0;
          upd_pc_r     <= 32'h0000_0000;
          taken_r      <= 1'b0;
          mispredict_r <= 1'b0;
        end
        default: begin
          state_r      <= ST_IDLE;
          upd_val_r    <= 1'b0;
          upd_pc_r     <= 32'h0000_0000;
          taken_r      <= 1'b0;
          mispredict_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pred_rdy      = pred_rdy_s;
  assign bus.resolve_rdy   = resolve_rdy_s;
  assign bus.upd_val       = upd_val_r;
  assign bus.upd_pc        = upd_pc_r;
  assign bus.mispredict    = mispredict_r;
  // Saturation flags come back from the PHT for upd_pc within the same cycle.
  assign bus.upd_increment = upd_val_r && taken_r && !bus.entry_upper_reached;
  assign bus.upd_decrement = upd_val_r && !taken_r && !bus.entry_lower_reached;

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches_r;
  logic [31:0] stat_mispredicts_r;

  // Count every update cycle and the mispredicting subset; wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_branches_r    <= 32'h0000_0000;
      stat_mispredicts_r <= 32'h0000_0000;
    end else if (upd_val_r) begin
      stat_branches_r <= stat_branches_r + 32'd1;
      if (mispredict_r) stat_mispredicts_r <= stat_mispredicts_r + 32'd1;
    end
  end

  assign stat_branches    = stat_branches_r;
  assign stat_mispredicts = stat_mispredicts_r;
`endif

endmodule
